// File: rtl/kan_tda_stream_bist_if.sv
// kan_tda_stream_bist_if: stimulus/response stream bundle between the BIST engine and the datapath under test
interface kan_tda_stream_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2
);
    logic [NUM_CH*DATA_WIDTH-1:0] stim_data;
    logic [NUM_CH-1:0]            stim_valid;
    logic [NUM_CH-1:0]            stim_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] resp_data;
    logic [NUM_CH-1:0]            resp_valid;
    logic [NUM_CH-1:0]            resp_ready;
    modport master (output stim_data, stim_valid, resp_ready, input stim_ready, resp_data, resp_valid);
    modport slave  (input stim_data, stim_valid, resp_ready, output stim_ready, resp_data, resp_valid);
endinterface

// File: rtl/kan_tda_stream_bist.sv
// kan_tda_stream_bist: multi-channel stream stimulus generator with per-channel MISR response check
module kan_tda_stream_bist #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_CH     = 2,
    parameter int                    POINT_DIM  = 3,
    parameter int                    CNT_W      = 16,
    parameter int                    TMO_W      = 20,
    parameter logic [DATA_WIDTH-1:0] POLY       = 32'h0040_0007
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [DATA_WIDTH-1:0]        seed,
    input  logic [CNT_W-1:0]             num_points,
    input  logic [CNT_W-1:0]             expected_resp,
    input  logic [TMO_W-1:0]             timeout_limit,
    input  logic [NUM_CH*DATA_WIDTH-1:0] golden_sig,
    kan_tda_stream_bist_if.master        st,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout_flag,
    output logic                         overrun_flag,
    output logic [TMO_W-1:0]             cycle_count,
    output logic [NUM_CH*DATA_WIDTH-1:0] signature
);
    localparam int TW = 2 * CNT_W;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t                               state_q, state_d;
    logic [1:0]                           mode_q, mode_d;
    logic [TW-1:0]                        total_q, total_d;
    logic [TMO_W-1:0]                     cyc_q, cyc_d;
    logic                                 tmo_q, tmo_d, ovr_q, ovr_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    gen_q, gen_d, sig_q, sig_d;
    logic [NUM_CH-1:0][TW-1:0]            sent_q, sent_d;
    logic [NUM_CH-1:0][CNT_W-1:0]         rcv_q, rcv_d;
    logic [NUM_CH-1:0]                    stim_valid, xfer, acc;
    logic                                 all_sent, all_rcvd, tmo_hit;

    function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] s);
        return (s << 1) ^ (s[DATA_WIDTH-1] ? POLY : '0);
    endfunction

    // LFSR channels are decorrelated by the channel index and never start from the all-zero lockup state
    function automatic logic [DATA_WIDTH-1:0] gen_init(input int c, input logic [1:0] m, input logic [DATA_WIDTH-1:0] sd);
        logic [DATA_WIDTH-1:0] s;
        s = sd ^ (DATA_WIDTH'(c) << 16);
        return m == 2'd0 ? (s == '0 ? DATA_WIDTH'(1) : s) : m == 2'd1 ? sd + DATA_WIDTH'(c) : sd;
    endfunction

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        total_d    = total_q;
        tmo_d      = tmo_q;
        ovr_d      = ovr_q;
        gen_d      = gen_q;
        sent_d     = sent_q;
        rcv_d      = rcv_q;
        sig_d      = sig_q;
        stim_valid = '0;
        xfer       = '0;
        acc        = '0;
        all_sent   = 1'b1;
        all_rcvd   = 1'b1;
        busy       = state_q == RUN || state_q == DRAIN;
        tmo_hit    = busy && timeout_limit != '0 && cyc_q == timeout_limit - 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            stim_valid[c] = state_q == RUN && sent_q[c] < total_q;
            xfer[c]       = stim_valid[c] && st.stim_ready[c];
            acc[c]        = busy && st.resp_valid[c];
            sent_d[c]     = sent_q[c] + TW'(xfer[c]);
            gen_d[c]      = !xfer[c] ? gen_q[c] : mode_q == 2'd0 ? step(gen_q[c]) :
                            mode_q == 2'd1 ? gen_q[c] + 1'b1 : gen_q[c];
            rcv_d[c]      = acc[c] && !(&rcv_q[c]) ? rcv_q[c] + 1'b1 : rcv_q[c];
            sig_d[c]      = acc[c] ? step(sig_q[c]) ^ st.resp_data[c*DATA_WIDTH +: DATA_WIDTH] : sig_q[c];
            ovr_d         = ovr_d || (acc[c] && rcv_q[c] == expected_resp);
            all_sent      = all_sent && sent_d[c] >= total_q;
            all_rcvd      = all_rcvd && rcv_d[c] >= expected_resp;
        end
        cyc_d = busy && !(&cyc_q) ? cyc_q + 1'b1 : cyc_q;
        if (tmo_hit) begin
            state_d = DONE;
            tmo_d   = 1'b1;
        end else if (state_q == RUN && all_sent) begin
            state_d = DRAIN;
        end else if (state_q == DRAIN && all_rcvd) begin
            state_d = DONE;
        end else if (!busy && start) begin
            state_d = RUN;
            mode_d  = mode;
            total_d = TW'(num_points) * TW'(POINT_DIM);
            cyc_d   = '0;
            tmo_d   = 1'b0;
            ovr_d   = 1'b0;
            sent_d  = '0;
            rcv_d   = '0;
            sig_d   = '0;
            for (int c = 0; c < NUM_CH; c++) gen_d[c] = gen_init(c, mode, seed);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            total_q <= '0;
            cyc_q   <= '0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
            gen_q   <= '0;
            sent_q  <= '0;
            rcv_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            total_q <= total_d;
            cyc_q   <= cyc_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
            gen_q   <= gen_d;
            sent_q  <= sent_d;
            rcv_q   <= rcv_d;
            sig_q   <= sig_d;
        end
    end

    assign st.stim_valid = stim_valid;
    assign st.stim_data  = gen_q;
    assign st.resp_ready = {NUM_CH{busy}};
    assign done          = state_q == DONE;
    assign pass          = done && !tmo_q && !ovr_q && sig_q == golden_sig;
    assign timeout_flag  = tmo_q;
    assign overrun_flag  = ovr_q;
    assign cycle_count   = cyc_q;
    assign signature     = sig_q;
endmodule

// File: tb/tb_kan_tda_stream_bist.sv
// tb_kan_tda_stream_bist: directed and randomized runs checked against a queue-based stream model
module tb_kan_tda_stream_bist;
    localparam int DW = 32, NC = 2, PD = 3, CW = 16, TW = 20;
    localparam logic [DW-1:0] POLY = 32'h0040_0007;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]        mode = '0;
    logic [DW-1:0]     seed = '0;
    logic [CW-1:0]     num_points = '0, expected_resp = '0;
    logic [TW-1:0]     timeout_limit = '0;
    logic [NC*DW-1:0]  golden_sig = '0;
    logic              busy, done, pass, timeout_flag, overrun_flag;
    logic [TW-1:0]     cycle_count;
    logic [NC*DW-1:0]  signature;
    logic              loop = 1'b1;
    logic [NC-1:0]     rdy_r = '1, rv_r = '0;
    int                rdy_mode = 0;
    int                vectors = 0, errors = 0;
    logic [DW-1:0]     got [NC][$];
    logic [DW-1:0]     exp_w [NC][$];
    logic [NC-1:0]     hold = '0;
    logic [DW-1:0]     held [NC];
    logic [NC*DW-1:0]  es;

    kan_tda_stream_bist_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    assign bus.stim_ready = rdy_r;
    assign bus.resp_valid = loop ? (bus.stim_valid & bus.stim_ready) : rv_r;
    assign bus.resp_data  = loop ? bus.stim_data : '0;

    kan_tda_stream_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
        .num_points(num_points), .expected_resp(expected_resp), .timeout_limit(timeout_limit),
        .golden_sig(golden_sig), .st(bus), .busy(busy), .done(done), .pass(pass),
        .timeout_flag(timeout_flag), .overrun_flag(overrun_flag), .cycle_count(cycle_count),
        .signature(signature)
    );

    always #5 clk = ~clk;

    // Transfers are recorded at the falling edge, i.e. the handshake that the next rising edge commits
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (rst_n && hold[c]) begin
                vectors++;
                assert ({bus.stim_valid[c], bus.stim_data[c*DW +: DW]} === {1'b1, held[c]})
                else begin
                    errors++;
                    $error("FAIL hold_ch%0d: observed %0h expected %0h", c,
                           {bus.stim_valid[c], bus.stim_data[c*DW +: DW]}, {1'b1, held[c]});
                end
            end
            if (rst_n && bus.stim_valid[c] && bus.stim_ready[c]) got[c].push_back(bus.stim_data[c*DW +: DW]);
            hold[c] = rst_n && bus.stim_valid[c] && !bus.stim_ready[c];
            held[c] = bus.stim_data[c*DW +: DW];
        end
    end

    function automatic logic [DW-1:0] lfsr(input logic [DW-1:0] s);
        return {s[DW-2:0], 1'b0} ^ (s[DW-1] ? POLY : '0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rdy_r = rdy_mode == 0 ? '1 : rdy_mode == 1 ? ~rdy_r : NC'($urandom);
    endtask

    // Expected word lists and loopback signatures straight from the generator and MISR rules
    task automatic build_model(input logic [1:0] m, input logic [DW-1:0] sd, input int np, output logic [NC*DW-1:0] sig);
        sig = '0;
        for (int c = 0; c < NC; c++) begin
            logic [DW-1:0] s, w;
            exp_w[c].delete();
            s = sd ^ (DW'(c) << 16);
            if (s == '0) s = 1;
            for (int k = 0; k < np * PD; k++) begin
                w = m == 2'd1 ? sd + DW'(c + k) : m == 2'd0 ? s : sd;
                exp_w[c].push_back(w);
                sig[c*DW +: DW] = lfsr(sig[c*DW +: DW]) ^ w;
                s = lfsr(s);
            end
        end
    endtask

    task automatic launch();
        for (int c = 0; c < NC; c++) got[c].delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_words(input string tag, input logic [NC*DW-1:0] sig);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s_ch%0d_count", tag, c), 64'(got[c].size()), 64'(exp_w[c].size()));
            for (int k = 0; k < got[c].size() && k < exp_w[c].size(); k++)
                chk($sformatf("%s_ch%0d_w%0d", tag, c, k), 64'(got[c][k]), 64'(exp_w[c][k]));
        end
        chk({tag, "_sig"}, 64'(signature), 64'(sig));
    endtask

    task automatic run_check(input string tag, input logic [1:0] m, input logic [DW-1:0] sd,
                             input int np, input int rmode, output logic [NC*DW-1:0] sig);
        build_model(m, sd, np, sig);
        mode = m;
        seed = sd;
        num_points = CW'(np);
        expected_resp = CW'(np * PD);
        timeout_limit = '0;
        loop = 1'b1;
        rdy_mode = rmode;
        golden_sig = sig;
        launch();
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, 2000);
        check_words(tag, sig);
        chk({tag, "_pass"}, 64'(pass), 64'd1);
        chk({tag, "_flags"}, 64'({timeout_flag, overrun_flag}), 64'd0);
        rdy_mode = 0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_status", 64'({busy, done, pass, timeout_flag, overrun_flag}), 64'd0);
        chk("reset_handshake", 64'({bus.stim_valid, bus.resp_ready}), 64'd0);
        chk("reset_counters", 64'(cycle_count), 64'd0);
        chk("reset_sig", 64'(signature), 64'd0);
        chk("reset_stim_data", 64'(bus.stim_data), 64'd0);
        rst_n = 1'b1;
        tick();

        build_model(2'd1, 32'h100, 4, es);
        mode = 2'd1; seed = 32'h100; num_points = 4; expected_resp = 12; golden_sig = es;
        launch();
        chk("ramp_first_valid", 64'(bus.stim_valid), 64'd3);
        chk("ramp_first_data", 64'(bus.stim_data), {32'h101, 32'h100});
        wait_done("ramp", 200);
        check_words("ramp", es);
        chk("ramp_cycles", 64'(cycle_count), 64'd13);
        chk("ramp_pass", 64'(pass), 64'd1);
        golden_sig = '0;
        #1;
        chk("golden_bad_pass", 64'(pass), 64'd0);
        chk("golden_bad_flags", 64'({timeout_flag, overrun_flag}), 64'd0);

        run_check("bp", 2'd1, 32'h100, 4, 1, es);
        run_check("lfsr", 2'd0, 32'h0, 11, 0, es);
        chk("lfsr_w31", 64'(got[0].size() > 31 ? got[0][31] : '0), 64'h8000_0000);
        chk("lfsr_w32", 64'(got[0].size() > 32 ? got[0][32] : '0), 64'h0040_0007);
        chk("lfsr_ch1_w0", 64'(got[1].size() > 0 ? got[1][0] : '0), 64'h0001_0000);
        run_check("zero", 2'd1, 32'h55, 0, 0, es);
        chk("zero_cycles", 64'(cycle_count), 64'd2);

        build_model(2'd1, 32'h100, 4, es);
        golden_sig = es; mode = 2'd1; seed = 32'h100; num_points = 4; expected_resp = 12;
        timeout_limit = 20; loop = 1'b0; rv_r = '0;
        launch();
        wait_done("tmo", 200);
        chk("tmo_flag", 64'(timeout_flag), 64'd1);
        chk("tmo_pass", 64'(pass), 64'd0);
        chk("tmo_cycles", 64'(cycle_count), 64'd20);
        timeout_limit = '0; loop = 1'b1;

        expected_resp = 11;
        launch();
        wait_done("ovr", 200);
        chk("ovr_flag", 64'({overrun_flag, timeout_flag}), 64'b10);
        chk("ovr_pass", 64'(pass), 64'd0);

        for (int i = 0; i < 4; i++)
            run_check($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 6), 2, es);

        build_model(2'd1, 32'h200, 4, es);
        mode = 2'd1; seed = 32'h200; num_points = 4; expected_resp = 12; golden_sig = es;
        launch();
        for (int n = 0; n < 50 && got[0].size() < 5; n++) tick();
        chk("mid_words", 64'(got[0].size()), 64'd5);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_status", 64'({busy, done, pass, timeout_flag, overrun_flag, bus.stim_valid, bus.resp_ready}), 64'd0);
        chk("mid_rst_counters", 64'(cycle_count), 64'd0);
        chk("mid_rst_sig", 64'(signature), 64'd0);
        rst_n = 1'b1;
        tick();
        launch();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", 200);
        check_words("busy_start", es);
        chk("busy_start_cycles", 64'(cycle_count), 64'd13);
        launch();
        chk("restart_cleared", 64'({busy, done, cycle_count, signature}), {1'b1, 1'b0, 20'd0, 64'd0});
        wait_done("restart", 200);
        check_words("restart", es);
        chk("restart_pass", 64'(pass), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
